omem_potential_store: RTL
=========================

OMEM_POTENTIAL_STORE -- requirements
Module: omem_potential_store

Interface
REQ-001 SHALL have parameter NUM_SPE, default 4, number of sum PEs served (local index 0..NUM_SPE-1, max 8).
REQ-002 SHALL have parameter OUT_PER_SPE, default 16, membrane-potential slots per SPE per timestep.
REQ-003 SHALL have parameter SPE_BASE_ADDR, default 8, network address of SPE index 0; SPE i is SPE_BASE_ADDR+i.
REQ-004 SHALL use one clock and one reset: reset is asynchronous and active-high (clk first, then reset).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 in_valid / in_ready  input / output  1 / 1  inbound packet handshake.
REQ-008 in_opcode  input  4  {spe_index[2:0], is_read}.
REQ-009 in_data  input  25  write: data[13:1]=potential (13b), data[0]=spike; read: ignored.
REQ-010 out_valid / out_ready  output / input  1 / 1  outbound packet handshake.
REQ-011 out_dest  output  4  destination address; out_opcode  output  4; out_data  output  25.
REQ-012 ts_done  output  1  one-cycle pulse when a timestep's last write is stored.
REQ-013 first_ts_done  output  1  sticky, set at end of timestep 1.
REQ-014 err  output  1  sticky protocol-error flag.
REQ-015 spike_count  output  16  spikes in the last completed timestep (see Configuration).

Function
REQ-016 SHALL implement states IDLE, RESP, BCAST; in_ready = 1 only in IDLE.
REQ-017 Transfer occurs on a rising edge where valid and ready are both 1; out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 Write ({i,0}, i<NUM_SPE): store potential and spike at slot wptr[i], increment wptr[i]; remain IDLE unless it completes the timestep.
REQ-019 Read ({i,1}, i<NUM_SPE): go to RESP; next cycle out_valid=1, out_dest=SPE_BASE_ADDR+i, out_opcode=2, out_data={12'b0, potential[rptr[i]]}; increment rptr[i] (wraps at OUT_PER_SPE); return to IDLE on transfer.
REQ-020 Read while first_ts_done=0 SHALL return potential 0 without advancing rptr[i].
REQ-021 Index i>=NUM_SPE, or write with wptr[i]==OUT_PER_SPE, SHALL be dropped, set err, and keep state IDLE.
REQ-022 When total writes in the timestep reach NUM_SPE*OUT_PER_SPE: pulse ts_done, clear all wptr, latch spike_count.
REQ-023 If that completion is the first timestep: set first_ts_done, enter BCAST, send NUM_SPE packets to i=0..NUM_SPE-1 in order, opcode 15, data 0, one per handshake; then IDLE.
REQ-024 Storage SHALL be single-buffered; a read of slot k SHALL precede the write of slot k within a timestep (SPE ordering), returning the prior timestep's value.
REQ-025 Potential SHALL be stored unmodified as 13 bits; no arithmetic on stored data.

Reset
REQ-026 On reset: state IDLE, in_ready=1 after deassertion, out_valid=0, out_dest/out_opcode/out_data=0, ts_done=0, first_ts_done=0, err=0, spike_count=0, all pointers and write counter 0.
REQ-027 Reset mid-RESP or mid-BCAST SHALL abort the packet immediately; memory contents need not be cleared.

Configuration
REQ-028 Macro OMEM_SPIKE_COUNT_EN: defined, spike_count latches the number of spike=1 writes of the completed timestep (saturating at 16'hFFFF); undefined, counter logic is omitted and spike_count is constant 0.

Verification
REQ-029 Reset, then read {0,1} -> out_valid next cycle, out_dest=8, out_opcode=2, out_data=0, rptr[0] unchanged.
REQ-030 64 writes (16 per SPE, potential=slot+1, spike=slot[0]) -> ts_done pulse on 64th, then 4 packets dest 8,9,10,11 opcode 15; spike_count=32 with macro, 0 without.
REQ-031 After REQ-030, read {2,1} twice -> out_data 1 then 2, dest 10.
REQ-032 Write {5,0} or 17th write to SPE 1 -> dropped, err=1, write count unchanged.
REQ-033 Hold out_ready=0 for 5 cycles in RESP -> out_* stable, in_ready=0; transfer on release.
REQ-034 Assert reset mid-BCAST after 2 packets -> out_valid=0, first_ts_done=0, state IDLE.

Source files
------------

// File: rtl/omem_potential_store.sv
// Membrane-potential output store: per-SPE write/read slot pointers, timestep tracking, first-timestep broadcast.
// Optional macro OMEM_SPIKE_COUNT_EN enables the per-timestep spike counter on spike_count.
module omem_potential_store #(
  parameter int NUM_SPE       = 4,
  parameter int OUT_PER_SPE   = 16,
  parameter int SPE_BASE_ADDR = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_opcode,
  input  logic [24:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_dest,
  output logic [3:0]  out_opcode,
  output logic [24:0] out_data,
  output logic        ts_done,
  output logic        first_ts_done,
  output logic        err,
  output logic [15:0] spike_count
);

  localparam int IW    = (NUM_SPE > 1) ? $clog2(NUM_SPE) : 1;
  localparam int PW    = (OUT_PER_SPE > 1) ? $clog2(OUT_PER_SPE) : 1;
  localparam int WW    = $clog2(OUT_PER_SPE + 1);
  localparam int TOTAL = NUM_SPE * OUT_PER_SPE;
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [3:0]    NUM_SPE_L = 4'(NUM_SPE);
  localparam logic [3:0]    BASE_L    = 4'(SPE_BASE_ADDR);
  localparam logic [WW-1:0] WFULL     = WW'(OUT_PER_SPE);
  localparam logic [PW-1:0] RLAST     = PW'(OUT_PER_SPE - 1);
  localparam logic [CW-1:0] CLAST     = CW'(TOTAL - 1);
  localparam logic [IW-1:0] BLAST     = IW'(NUM_SPE - 1);

  typedef enum logic [1:0] {IDLE, RESP, BCAST} state_t;
  state_t state_q, state_d;

  logic [12:0]   mem  [NUM_SPE][OUT_PER_SPE];
  logic [WW-1:0] wptr [NUM_SPE];
  logic [PW-1:0] rptr [NUM_SPE];
  logic [CW-1:0] wr_cnt;
  logic [IW-1:0] bc_idx;

  logic [IW-1:0] sidx;
  logic          is_rd, idx_ok, wr_full, in_fire;
  logic          rd_acc, wr_acc, drop, ts_last;
  logic          unused_in;

  assign in_ready  = (state_q == IDLE);
  assign sidx      = in_opcode[IW:1];
  assign is_rd     = in_opcode[0];
  assign idx_ok    = ({1'b0, in_opcode[3:1]} < NUM_SPE_L);
  assign wr_full   = (wptr[sidx] == WFULL);
  assign in_fire   = in_valid && in_ready;
  assign rd_acc    = in_fire && is_rd && idx_ok;
  assign wr_acc    = in_fire && !is_rd && idx_ok && !wr_full;
  assign drop      = in_fire && (!idx_ok || (!is_rd && wr_full));
  assign ts_last   = wr_acc && (wr_cnt == CLAST);
  assign unused_in = ^{in_data[24:14], in_data[0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ts_last && !first_ts_done) state_d = BCAST;
        else if (rd_acc)               state_d = RESP;
      end
      RESP:    if (out_ready) state_d = IDLE;
      BCAST:   if (out_ready && bc_idx == BLAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Potential memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[sidx][wptr[sidx][PW-1:0]] <= in_data[13:1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_dest      <= '0;
      out_opcode    <= '0;
      out_data      <= '0;
      ts_done       <= 1'b0;
      first_ts_done <= 1'b0;
      err           <= 1'b0;
      wr_cnt        <= '0;
      bc_idx        <= '0;
      for (int unsigned k = 0; k < NUM_SPE; k++) begin
        wptr[k] <= '0;
        rptr[k] <= '0;
      end
    end else begin
      ts_done <= ts_last;
      if (drop) err <= 1'b1;
      if (wr_acc) begin
        wptr[sidx] <= wptr[sidx] + 1'b1;
        wr_cnt     <= wr_cnt + 1'b1;
      end
      // Timestep completion overrides the per-write increments above.
      if (ts_last) begin
        wr_cnt <= '0;
        for (int unsigned k = 0; k < NUM_SPE; k++) wptr[k] <= '0;
        if (!first_ts_done) begin
          first_ts_done <= 1'b1;
          out_valid     <= 1'b1;
          out_dest      <= BASE_L;
          out_opcode    <= 4'd15;
          out_data      <= '0;
          bc_idx        <= '0;
        end
      end
      if (rd_acc) begin
        out_valid  <= 1'b1;
        out_dest   <= BASE_L + 4'(sidx);
        out_opcode <= 4'd2;
        if (first_ts_done) begin
          out_data   <= {12'b0, mem[sidx][rptr[sidx]]};
          rptr[sidx] <= (rptr[sidx] == RLAST) ? '0 : rptr[sidx] + 1'b1;
        end else begin
          out_data <= '0;
        end
      end
      if (state_q == RESP && out_ready) out_valid <= 1'b0;
      if (state_q == BCAST && out_ready) begin
        if (bc_idx == BLAST) begin
          out_valid <= 1'b0;
        end else begin
          bc_idx   <= bc_idx + 1'b1;
          out_dest <= out_dest + 4'd1;
        end
      end
    end
  end

`ifdef OMEM_SPIKE_COUNT_EN
  logic [15:0] spike_acc, spike_next;

  always_comb begin
    spike_next = spike_acc;
    if (wr_acc && in_data[0] && spike_acc != 16'hFFFF) spike_next = spike_acc + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spike_acc   <= '0;
      spike_count <= '0;
    end else if (ts_last) begin
      spike_count <= spike_next;
      spike_acc   <= '0;
    end else begin
      spike_acc <= spike_next;
    end
  end
`else
  assign spike_count = '0;
`endif

endmodule
